// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_multi
//  Purpose  : Multi-channel PWM generator. One shared period counter drives
//             CHANNELS outputs, each with its own duty value and enable.
//             Period/duty/enable updates are double-buffered so that they
//             only land on a period boundary. STOP lets the current period
//             finish before going idle.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset
//             set        - load request for period/duty/ch_en
//             stop       - stop after the current period completes
//             period     - period length in clk cycles (0 is ignored)
//             duty       - per-channel high time, channel i at [i*WIDTH +: WIDTH]
//             ch_en      - per-channel enable
//             pwm        - registered PWM outputs
//             busy       - running or draining
//             rdy        - a set would not overwrite a pending update
//             period_end - high on the last cycle of each period
//             pend       - a staged update waits for the next boundary
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic                      stop,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       ch_en,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      busy,
  output logic                      rdy,
  output logic                      period_end,
  output logic                      pend
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                           r_state, w_state;
  logic [WIDTH-1:0]                 r_cnt,   w_cnt;
  // Shadow set drives the outputs; staging set holds a mid-period update.
  logic [WIDTH-1:0]                 r_p_sh,  w_p_sh;
  logic [WIDTH-1:0]                 r_p_st,  w_p_st;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_d_sh,  w_d_sh;
  logic [CHANNELS-1:0][WIDTH-1:0]   r_d_st,  w_d_st;
  logic [CHANNELS-1:0]              r_e_sh,  w_e_sh;
  logic [CHANNELS-1:0]              r_e_st,  w_e_st;
  logic [CHANNELS-1:0]              r_pwm,   w_pwm;
  logic                             r_pend,  w_pend;

  logic                             w_at_end;
  logic                             w_set_ok;

  // Last cycle of the current period; shadow period is never 0 outside IDLE.
  assign w_at_end = (r_state != S_IDLE) && (r_cnt == (r_p_sh - C_ONE));
  assign w_set_ok = set && (period != '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p_sh  <= '0;
      r_p_st  <= '0;
      r_d_sh  <= '0;
      r_d_st  <= '0;
      r_e_sh  <= '0;
      r_e_st  <= '0;
      r_pend  <= 1'b0;
      r_pwm   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_p_sh  <= w_p_sh;
      r_p_st  <= w_p_st;
      r_d_sh  <= w_d_sh;
      r_d_st  <= w_d_st;
      r_e_sh  <= w_e_sh;
      r_e_st  <= w_e_st;
      r_pend  <= w_pend;
      r_pwm   <= w_pwm;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_p_sh  = r_p_sh;
    w_p_st  = r_p_st;
    w_d_sh  = r_d_sh;
    w_d_st  = r_d_st;
    w_e_sh  = r_e_sh;
    w_e_st  = r_e_st;
    w_pend  = r_pend;

    case (r_state)
      S_IDLE: begin
        if (w_set_ok) begin
          w_p_sh  = period;
          w_d_sh  = duty;
          w_e_sh  = ch_en;
          w_cnt   = '0;
          w_state = S_RUN;
        end
      end

      S_RUN: begin
        w_cnt = w_at_end ? '0 : (r_cnt + C_ONE);
        if (w_at_end) begin
          // A set arriving on the boundary cycle bypasses staging entirely.
          if (w_set_ok && !stop) begin
            w_p_sh = period;
            w_d_sh = duty;
            w_e_sh = ch_en;
          end else if (r_pend) begin
            w_p_sh = r_p_st;
            w_d_sh = r_d_st;
            w_e_sh = r_e_st;
          end
          w_pend = 1'b0;
        end else if (w_set_ok && !stop) begin
          w_p_st = period;
          w_d_st = duty;
          w_e_st = ch_en;
          w_pend = 1'b1;
        end
        if (stop) begin
          w_state = S_DRAIN;
        end
      end

      S_DRAIN: begin
        w_cnt = w_at_end ? '0 : (r_cnt + C_ONE);
        if (w_at_end) begin
          w_state = S_IDLE;
          w_pend  = 1'b0;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_pend  = 1'b0;
      end
    endcase
  end

  // PWM is registered, so it is computed from the next counter and next
  // shadow values; this gives the high level on the first cycle after a set.
  always_comb begin
    w_pwm = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_pwm[i] = (w_state != S_IDLE) && w_e_sh[i] && (w_cnt < w_d_sh[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pwm        = r_pwm;
  assign busy       = (r_state != S_IDLE);
  assign pend       = r_pend;
  assign rdy        = (r_state == S_IDLE) || ((r_state == S_RUN) && !r_pend);
  assign period_end = w_at_end;

endmodule
`default_nettype wire

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel PWM control/data path pair.
- One period counter is shared by CHANNELS outputs. Each channel has its own duty value and enable.
- New period/duty settings are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period.
- STOP is graceful: the current period completes before the block goes idle.

Parameters:
WIDTH, 8, bit width of period, duty and counter
CHANNELS, 4, number of PWM outputs

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous active-high reset
SET  in  1  request to load PERIOD/DUTY/CH_EN (sampled each cycle)
STOP  in  1  request to stop after the current period
PERIOD  in  WIDTH  period length in CLK cycles; 0 is illegal
DUTY  in  CHANNELS*WIDTH  per-channel high-time; channel i at bits [i*WIDTH +: WIDTH]
CH_EN  in  CHANNELS  per-channel enable; a disabled channel outputs 0
PWM  out  CHANNELS  PWM outputs, registered
BUSY  out  1  state is RUN or DRAIN
RDY  out  1  a SET would be accepted without overwriting a pending update
PERIOD_END  out  1  one-cycle pulse on the last cycle of each period
PEND  out  1  a staged update is waiting for the period boundary

Behaviour:
- Reset, synchronous on RST=1 at an edge:
  - state=IDLE; CNT, shadow and staging registers = 0.
  - PWM=0, BUSY=0, PEND=0, PERIOD_END=0, RDY=1.
  - RST overrides every other input. A reset mid-period drops PWM to 0 on that edge.
- Registers:
  - Shadow set (P_sh, D_sh[i], E_sh) drives the outputs.
  - Staging set (P_st, D_st[i], E_st) holds an update captured while running.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - SET=1 and PERIOD!=0 -> shadow <= inputs, CNT <= 0, go to RUN.
  - SET with PERIOD=0 is ignored (stay IDLE).
  - STOP is ignored.
- RUN:
  - CNT increments each cycle. At CNT==P_sh-1: PERIOD_END=1 that cycle; next edge CNT <= 0.
  - STOP=1 -> DRAIN on the next edge. STOP has priority over a simultaneous SET; that SET is discarded.
  - SET=1 with PERIOD!=0, not at a boundary cycle -> staging <= inputs, PEND <= 1. A second SET overwrites the staging set (last wins).
  - At the boundary edge:
    - If SET is valid in that same cycle, shadow <= inputs directly.
    - Else if PEND=1, shadow <= staging.
    - In both cases PEND <= 0.
  - SET with PERIOD=0 is ignored and PEND is unchanged.
- DRAIN:
  - Counting and PWM continue unchanged. SET and STOP are ignored; any PEND is discarded at exit.
  - At the boundary edge: state <= IDLE, CNT <= 0, PEND <= 0.
- PWM timing:
  - In RUN/DRAIN, during the cycle with CNT==c, PWM[i] = E_sh[i] && (c < D_sh[i]).
  - The first high cycle is the cycle right after the SET edge, i.e. 1-cycle latency.
  - D=0 gives constant low. D>=P_sh gives constant high (100%). In IDLE, PWM=0.
- Arithmetic: compares are unsigned WIDTH-bit. CNT never exceeds P_sh-1, so P=2^WIDTH-1 is the longest period.
- P_sh=1: CNT stays 0 and PERIOD_END is high every cycle in RUN.
- Combinational outputs:
  - BUSY = (state!=IDLE).
  - PEND is the register value.
  - RDY = (state==IDLE) || (state==RUN && !PEND).
  - PERIOD_END is combinational from state, CNT and P_sh.

Test Plan:
- Basic waveform (WIDTH=8, CHANNELS=4): RST; SET with PERIOD=10, DUTY={ch3:0, ch2:10, ch1:3, ch0:5}, CH_EN=4'b1111 -> ch0 high 5/10 cycles, ch1 3/10, ch2 always high, ch3 always low; PERIOD_END every 10th cycle; BUSY=1; first ch0 high one cycle after the SET edge.
- Buffered update: mid-period (CNT=4), SET with PERIOD=6, ch0 duty=2 -> PEND=1, RDY=0; old waveform continues until CNT=9; from the next cycle the period is 6 and ch0 is high 2 cycles; PEND=0.
- Boundary collision: SET asserted exactly when CNT==P_sh-1 -> new values take effect at CNT=0 of the next period; PEND never goes to 1.
- Graceful stop: STOP at CNT=2 with P=10 -> PWM continues through CNT=9, then state is IDLE, all PWM=0, BUSY=0, RDY=1; a SET or STOP during DRAIN has no effect.
- Edge cases:
  - SET with PERIOD=0 in IDLE -> stays IDLE.
  - PERIOD=1, duty=1 -> constant high, PERIOD_END high every cycle.
  - CH_EN[1]=0 -> PWM[1]=0 regardless of its duty.
- Reset mid-run: RST pulse at CNT=3 with pending update -> next cycle PWM=0, PEND=0, BUSY=0, RDY=1; STOP+SET together in RUN -> DRAIN, and the SET is dropped.
